// File: rtl/pokey_pkg.sv
// pokey_pkg: AUDC register field positions shared by the POKEY channel blocks.
package pokey_pkg;
    localparam int AUDC_POLY5_N   = 7;
    localparam int AUDC_POLY4_SEL = 6;
    localparam int AUDC_PURE      = 5;
    localparam int AUDC_VOLONLY   = 4;
    localparam int AUDC_VOL_MSB   = 3;
endpackage

// File: rtl/pokey_hipass.sv
// pokey_hipass: high-pass flip-flop clocked by the partner channel, XOR-mixed with the tone.
module pokey_hipass
    import pokey_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic hp_ev_i,
    input  logic hp_en_i,
    input  logic tone_i,
    output logic out_bit_o
);
    logic hp_q;
    // Samples the tone before this cycle's tone update lands.
    always_ff @(posedge clk or posedge reset)
        if (reset) hp_q <= 1'b0;
        else if (hp_ev_i) hp_q <= tone_i;
    assign out_bit_o = hp_en_i ? (tone_i ^ hp_q) : tone_i;
endmodule

// File: rtl/pokey_chan_out.sv
// pokey_chan_out: channel output stage - reload strobe, distortion, tone flip-flop, volume gate.
// Define POKEY_HIPASS_EN to build the partner-clocked high-pass mix.
module pokey_chan_out
    import pokey_pkg::*;
#(
    parameter int VOL_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enp,
    input  logic             bor,
    input  logic [7:0]       audc,
    input  logic             poly4,
    input  logic             poly5,
    input  logic             poly17,
    input  logic             hp_clk,
    input  logic             hp_en,
    output logic             reload,
    output logic             tone,
    output logic [VOL_W-1:0] vol
);
    logic ev_q, p4_q, p5_q, p17_q, tone_q, tone_d, out_bit;
    logic [VOL_W-1:0] vol_q, vol_d;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            ev_q   <= 1'b0;
            p4_q   <= 1'b0;
            p5_q   <= 1'b0;
            p17_q  <= 1'b0;
            tone_q <= 1'b0;
            vol_q  <= '0;
        end else begin
            ev_q   <= enp & bor;
            p4_q   <= poly4;
            p5_q   <= poly5;
            p17_q  <= poly17;
            tone_q <= tone_d;
            vol_q  <= vol_d;
        end
    always_comb begin
        tone_d = (ev_q & (audc[AUDC_POLY5_N] | p5_q))
               ? (audc[AUDC_PURE] ? ~tone_q : (audc[AUDC_POLY4_SEL] ? p4_q : p17_q))
               : tone_q;
        vol_d  = (audc[AUDC_VOLONLY] | out_bit) ? audc[AUDC_VOL_MSB -: VOL_W] : '0;
    end
`ifdef POKEY_HIPASS_EN
    logic hp_ev_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) hp_ev_q <= 1'b0;
        else hp_ev_q <= enp & hp_clk;
    pokey_hipass u_hipass (
        .clk       (clk),
        .reset     (reset),
        .hp_ev_i   (hp_ev_q),
        .hp_en_i   (hp_en),
        .tone_i    (tone_q),
        .out_bit_o (out_bit)
    );
`else
    logic unused_hp;
    assign unused_hp = hp_clk ^ hp_en;
    assign out_bit   = tone_q;
`endif
    assign reload = ev_q;
    assign tone   = tone_q;
    assign vol    = vol_q;
endmodule

// File: tb/tb_pokey_chan_out.sv
// tb_pokey_chan_out: directed checks of reload timing, distortion, volume and high-pass mix.
module tb_pokey_chan_out;
    logic clk = 1'b0, reset = 1'b1, enp = 1'b1, bor = 1'b0;
    logic [7:0] audc = 8'h00;
    logic poly4 = 1'b0, poly5 = 1'b0, poly17 = 1'b0, hp_clk = 1'b0, hp_en = 1'b0;
    logic reload, tone;
    logic [3:0] vol;
    int n_cmp = 0, n_err = 0;
`ifdef POKEY_HIPASS_EN
    localparam bit HP = 1'b1;
`else
    localparam bit HP = 1'b0;
`endif

    pokey_chan_out #(.VOL_W(4)) dut (
        .clk(clk), .reset(reset), .enp(enp), .bor(bor), .audc(audc),
        .poly4(poly4), .poly5(poly5), .poly17(poly17),
        .hp_clk(hp_clk), .hp_en(hp_en),
        .reload(reload), .tone(tone), .vol(vol)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic r, input logic t, input logic [3:0] v);
        chk({tag, ".reload"}, {7'b0, reload}, {7'b0, r});
        chk({tag, ".tone"},   {7'b0, tone},   {7'b0, t});
        chk({tag, ".vol"},    {4'b0, vol},    {4'b0, v});
    endtask

    initial begin
        tick; tick;
        chk3("reset", 0, 0, 4'd0);
        reset = 1'b0;
        tick; tick;
        chk3("idle", 0, 0, 4'd0);
        // pure tone, event every 4th enp
        audc = 8'hA8;
        bor = 1; tick; bor = 0;
        chk3("pure1.n1", 1, 0, 4'd0);
        tick; chk3("pure1.n2", 0, 1, 4'd0);
        tick; chk3("pure1.n3", 0, 1, 4'd8);
        tick;
        bor = 1; tick; bor = 0;
        chk3("pure2.n1", 1, 1, 4'd8);
        tick; chk3("pure2.n2", 0, 0, 4'd8);
        tick; chk3("pure2.n3", 0, 0, 4'd0);
        // bor without enp is ignored
        enp = 0; bor = 1; tick; bor = 0; enp = 1;
        chk3("noenp.n1", 0, 0, 4'd0);
        tick; chk3("noenp.n2", 0, 0, 4'd0);
        // back-to-back events
        bor = 1; tick; chk3("b2b.a", 1, 0, 4'd0);
        tick; bor = 0; chk3("b2b.b", 1, 1, 4'd0);
        tick; chk3("b2b.c", 0, 0, 4'd8);
        tick; chk3("b2b.d", 0, 0, 4'd0);
        // async reset mid-operation
        bor = 1; tick; bor = 0; tick; tick;
        chk3("prerst", 0, 1, 4'd8);
        #2 reset = 1; #1;
        chk3("asyncrst", 0, 0, 4'd0);
        #2 reset = 0;
        bor = 1; tick; bor = 0;
        chk3("postrst.n1", 1, 0, 4'd0);
        tick; chk3("postrst.n2", 0, 1, 4'd0);
        // poly5 gating
        audc = 8'h28;
        poly5 = 0; bor = 1; tick; bor = 0;
        tick; chk("p5gate.hold", {7'b0, tone}, 8'd1);
        poly5 = 1; bor = 1; tick; bor = 0; poly5 = 0;
        tick; chk("p5gate.toggle", {7'b0, tone}, 8'd0);
        // poly4 captured at event cycle
        audc = 8'hC6;
        poly4 = 1; bor = 1; tick; bor = 0; poly4 = 0;
        tick; chk3("p4.n2", 0, 1, 4'd0);
        tick; chk3("p4.n3", 0, 1, 4'd6);
        // poly17 select
        audc = 8'h86; poly4 = 1; poly17 = 0;
        bor = 1; tick; bor = 0;
        tick; chk("p17.tone", {7'b0, tone}, 8'd0);
        tick; chk("p17.vol", {4'b0, vol}, 8'd0);
        poly4 = 0;
        // volume-only
        audc = 8'h1F;
        tick; chk3("volonly", 0, 0, 4'd15);
        audc = 8'h13;
        tick; chk("volonly.chg", {4'b0, vol}, 8'd3);
        // high-pass mix (ignored when not built)
        audc = 8'hA8; hp_en = 1;
        bor = 1; tick; bor = 0; tick; tick;
        chk3("hp.pre", 0, 1, 4'd8);
        bor = 1; hp_clk = 1; tick; bor = 0; hp_clk = 0;
        tick; chk("hp.tone", {7'b0, tone}, 8'd0);
        tick; chk("hp.mix", {4'b0, vol}, HP ? 8'd8 : 8'd0);
        hp_en = 0;
        tick; chk("hp.off", {4'b0, vol}, 8'd0);
        hp_en = 1;
        tick; chk("hp.retain", {4'b0, vol}, HP ? 8'd8 : 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
